v30mz_mem_responder: RTL

Bus-side responder answering the memory bus cycles issued by the `v30mz` core. It decodes `bus_status`, latches the cycle's address and write data, and runs the access on a request/acknowledge memory port. It then inserts a programmable number of wait states and answers with a one-cycle active-low `readyb` strobe, carrying read data on `data_in`. It sits between the core and the on-chip memory/ROM fabric.

---
 rtl/v30mz_pkg.sv | 24 ++
 rtl/v30mz_wait_counter.sv | 28 ++
 rtl/v30mz_mem_responder.sv | 106 ++++++++++
 3 files changed

// File: rtl/v30mz_pkg.sv
// Shared definitions for the v30mz core and its bus-side responders:
// bus-status codes and the memory responder state encoding.
package v30mz_pkg;

   localparam logic [3:0] BS_CODE_READ = 4'b1001;
   localparam logic [3:0] BS_MEM_READ  = 4'b1010;
   localparam logic [3:0] BS_MEM_WRITE = 4'b1011;
   localparam logic [3:0] BS_PASSIVE   = 4'b1111;

   localparam int unsigned WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_READY   = 2'd2,
      ST_RECOVER = 2'd3
   } resp_state_t;

   // I/O and other codes are served elsewhere and never start a memory access.
   function automatic logic is_mem_cycle(input logic [3:0] bs);
      return (bs == BS_CODE_READ) || (bs == BS_MEM_READ) || (bs == BS_MEM_WRITE);
   endfunction

endpackage

// File: rtl/v30mz_wait_counter.sv
// Wait-state down-counter: loads at the start of an access, decrements
// toward zero, and flags when the minimum wait has elapsed.
module v30mz_wait_counter
   import v30mz_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  dec,
   input  logic [WAIT_CNT_W-1:0] load_val,
   output logic                  zero
);

   logic [WAIT_CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/v30mz_mem_responder.sv
// Memory bus responder for the v30mz core: runs one request/acknowledge
// access per bus cycle and answers with a single-cycle active-low readyb.
//
// state   | meaning
// IDLE    | waiting for a fetch/read/write status from the core
// ACCESS  | mem_req outstanding and/or wait states still running
// READY   | readyb low for this one cycle, read data on data_in
// RECOVER | waiting for passive status so a stale code cannot retrigger
module v30mz_mem_responder
   import v30mz_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] address_out,
   input  logic [3:0]  bus_status,
   input  logic        bhe_n,
   input  logic [15:0] wdata,
   output logic        readyb,
   output logic [15:0] data_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [18:0] mem_addr,
   output logic [1:0]  mem_be,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata
);

   resp_state_t state, state_nxt;

   logic        ack_seen;
   logic [15:0] rdata_q;
   logic        cnt_zero;
   logic        accept;
   logic        ack_hit;
   logic        done;

   v30mz_wait_counter u_wait_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .dec      (state == ST_ACCESS),
      .load_val (WAIT_CNT_W'(WAIT_STATES)),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:    if (is_mem_cycle(bus_status)) state_nxt = ST_ACCESS;
         ST_ACCESS:  if (done) state_nxt = ST_READY;
         ST_READY:   state_nxt = ST_RECOVER;
         ST_RECOVER: if (bus_status == BS_PASSIVE) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Acks outside an outstanding request (stray or post-reset) are dropped here.
   always_comb begin
      accept  = (state == ST_IDLE) && is_mem_cycle(bus_status);
      ack_hit = (state == ST_ACCESS) && mem_req && mem_ack;
      done    = (state == ST_ACCESS) && (ack_seen || ack_hit) && cnt_zero;
      readyb  = (state != ST_READY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_in   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         ack_seen  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (accept) begin
            mem_req   <= 1'b1;
            mem_we    <= (bus_status == BS_MEM_WRITE);
            mem_addr  <= address_out[19:1];
            mem_be    <= (bus_status == BS_MEM_WRITE) ? {~bhe_n, ~address_out[0]} : 2'b11;
            mem_wdata <= wdata;
            ack_seen  <= 1'b0;
         end
         if (ack_hit) begin
            mem_req  <= 1'b0;
            ack_seen <= 1'b1;
            if (!mem_we) rdata_q <= mem_rdata;
         end
         if (done && !mem_we) begin
            data_in <= ack_hit ? mem_rdata : rdata_q;
         end
      end
   end

endmodule
